// File: rtl/servo_pkg.sv
// servo_pkg: shared defaults and servo timing constants for the PWM output stage.
// The optional saturation flags are enabled by defining SERVO_PWM_SAT_EN.
package servo_pkg;

  localparam int DEF_N          = 19;
  localparam int DEF_FRAC       = 8;
  localparam int SERVO_PERIOD   = 20000;
  localparam int SERVO_OFFSET   = 1500;
  localparam int SERVO_DUTY_MIN = 1000;
  localparam int SERVO_DUTY_MAX = 2000;
  localparam int SERVO_CW       = $clog2(SERVO_PERIOD + 1);

  typedef logic [SERVO_CW-1:0] duty_t;

  // Clamp an integer into [lo, hi]; used for elaboration-time constants.
  function automatic int clamp_int(input int v, input int lo, input int hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

endpackage

// File: rtl/servo_duty_clamp.sv
// servo_duty_clamp: signed controller output -> clamped pulse width in ticks.
// With SERVO_PWM_SAT_EN defined it also reports which clamp limit engaged.
module servo_duty_clamp
  import servo_pkg::*;
#(
  parameter int N        = DEF_N,
  parameter int FRAC     = DEF_FRAC,
  parameter int OFFSET   = SERVO_OFFSET,
  parameter int DUTY_MIN = SERVO_DUTY_MIN,
  parameter int DUTY_MAX = SERVO_DUTY_MAX,
  parameter int CW       = SERVO_CW
) (
  input  logic [N-1:0]  u,
  output logic [CW-1:0] duty
`ifdef SERVO_PWM_SAT_EN
  ,
  output logic          sat_hi,
  output logic          sat_lo
`endif
);

  localparam logic signed [N:0] OFF_W = (N+1)'(OFFSET);
  localparam logic signed [N:0] MIN_W = (N+1)'(DUTY_MIN);
  localparam logic signed [N:0] MAX_W = (N+1)'(DUTY_MAX);

  logic signed [N:0] u_ext;
  logic signed [N:0] w;

  // One extra sign bit keeps shift-plus-offset from wrapping before the clamp.
  always_comb begin
    u_ext = $signed({u[N-1], u});
    w     = (u_ext >>> FRAC) + OFF_W;
    if (w > MAX_W) begin
      duty = CW'(DUTY_MAX);
    end else if (w < MIN_W) begin
      duty = CW'(DUTY_MIN);
    end else begin
      duty = w[CW-1:0];
    end
  end

`ifdef SERVO_PWM_SAT_EN
  // Flags mirror the clamp decision for upstream anti-windup.
  always_comb begin
    sat_hi = (w > MAX_W);
    sat_lo = (w < MIN_W);
  end
`endif

endmodule

// File: rtl/servo_pwm_gen.sv
// servo_pwm_gen: double-buffered servo PWM with once-per-period sample_tick.
// Define SERVO_PWM_SAT_EN to add the sat_hi/sat_lo anti-windup outputs.
module servo_pwm_gen
  import servo_pkg::*;
#(
  parameter int N        = DEF_N,
  parameter int FRAC     = DEF_FRAC,
  parameter int PRESC    = 50,
  parameter int PERIOD   = SERVO_PERIOD,
  parameter int OFFSET   = SERVO_OFFSET,
  parameter int DUTY_MIN = SERVO_DUTY_MIN,
  parameter int DUTY_MAX = SERVO_DUTY_MAX,
  localparam int CW      = $clog2(PERIOD + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [N-1:0]  u,
  input  logic          u_valid,
  output logic          pwm,
  output logic          sample_tick,
  output logic [CW-1:0] duty
`ifdef SERVO_PWM_SAT_EN
  ,
  output logic          sat_hi,
  output logic          sat_lo
`endif
);

  localparam int            PW       = (PRESC > 1) ? $clog2(PRESC) : 1;
  localparam logic [CW-1:0] RST_DUTY = CW'(clamp_int(OFFSET, DUTY_MIN, DUTY_MAX));
  localparam logic [PW-1:0] PC_LAST  = PW'(PRESC - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(PERIOD - 1);

  logic [PW-1:0] pc_q, pc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] shadow_q, shadow_d;
  logic [CW-1:0] active_q, active_d;
  logic          pwm_q, pwm_d;
  logic          tick_q, tick_d;
  logic          en_q, en_d;
  logic [CW-1:0] conv_duty;

`ifdef SERVO_PWM_SAT_EN
  logic conv_sat_hi, conv_sat_lo;
  logic sat_hi_q, sat_hi_d, sat_lo_q, sat_lo_d;
`endif

  servo_duty_clamp #(
    .N        (N),
    .FRAC     (FRAC),
    .OFFSET   (OFFSET),
    .DUTY_MIN (DUTY_MIN),
    .DUTY_MAX (DUTY_MAX),
    .CW       (CW)
  ) u_clamp (
    .u    (u),
    .duty (conv_duty)
`ifdef SERVO_PWM_SAT_EN
    ,
    .sat_hi (conv_sat_hi),
    .sat_lo (conv_sat_lo)
`endif
  );

  // Prescaler, period counter and shadow->active handover at each period start.
  always_comb begin
    pc_d     = pc_q;
    cnt_d    = cnt_q;
    active_d = active_q;
    tick_d   = 1'b0;
    pwm_d    = 1'b0;
    en_d     = en;
    shadow_d = u_valid ? conv_duty : shadow_q;
    if (!en) begin
      pc_d  = '0;
      cnt_d = '0;
    end else if (!en_q) begin
      // First enabled clock opens a fresh period; pwm rises one clock later.
      pc_d     = '0;
      cnt_d    = '0;
      tick_d   = 1'b1;
      active_d = shadow_q;
    end else begin
      pwm_d = (cnt_q < active_q);
      if (pc_q == PC_LAST) begin
        pc_d = '0;
        if (cnt_q == CNT_LAST) begin
          cnt_d    = '0;
          tick_d   = 1'b1;
          active_d = shadow_q;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end else begin
        pc_d = pc_q + PW'(1);
      end
    end
  end

  // Core state; reset restores the centred width and silences the output at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q     <= '0;
      cnt_q    <= '0;
      shadow_q <= RST_DUTY;
      active_q <= RST_DUTY;
      pwm_q    <= 1'b0;
      tick_q   <= 1'b0;
      en_q     <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
      pwm_q    <= pwm_d;
      tick_q   <= tick_d;
      en_q     <= en_d;
    end
  end

`ifdef SERVO_PWM_SAT_EN
  // Saturation flags follow the most recent conversion, like shadow.
  always_comb begin
    sat_hi_d = u_valid ? conv_sat_hi : sat_hi_q;
    sat_lo_d = u_valid ? conv_sat_lo : sat_lo_q;
  end

  // Saturation flag registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sat_hi_q <= 1'b0;
      sat_lo_q <= 1'b0;
    end else begin
      sat_hi_q <= sat_hi_d;
      sat_lo_q <= sat_lo_d;
    end
  end

  assign sat_hi = sat_hi_q;
  assign sat_lo = sat_lo_q;
`endif

  assign pwm         = pwm_q;
  assign sample_tick = tick_q;
  assign duty        = active_q;

endmodule

// File: tb/tb_servo_pwm_gen.sv
// tb_servo_pwm_gen: directed plus randomized checks of servo_pwm_gen against a
// period-level model (widths, tick spacing, double-buffered width handover).
module tb_servo_pwm_gen;

  localparam int N      = 19;
  localparam int PRESC  = 2;
  localparam int PERIOD = 20;
  localparam int OFFSET = 10;
  localparam int DMIN   = 5;
  localparam int DMAX   = 15;
  localparam int CW     = $clog2(PERIOD + 1);
  localparam int CLKS   = PERIOD * PRESC;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b0;
  logic          u_valid = 1'b0;
  logic          u_valid4 = 1'b0;
  logic [N-1:0]  u = '0;
  logic [N-1:0]  u4 = '0;
  logic          pwm, sample_tick, pwm4, sample_tick4;
  logic [CW-1:0] duty, duty4;
`ifdef SERVO_PWM_SAT_EN
  logic          sat_hi, sat_lo, sat_hi4, sat_lo4;
  bit            shi_m = 1'b0;
  bit            slo_m = 1'b0;
`endif

  int n_vec = 0;
  int n_err = 0;
  int shadow_m = 10;
  int active_m = 10;

  always #5 clk = ~clk;

  servo_pwm_gen #(
    .N(N), .FRAC(0), .PRESC(PRESC), .PERIOD(PERIOD),
    .OFFSET(OFFSET), .DUTY_MIN(DMIN), .DUTY_MAX(DMAX)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .u(u), .u_valid(u_valid),
    .pwm(pwm), .sample_tick(sample_tick), .duty(duty)
`ifdef SERVO_PWM_SAT_EN
    , .sat_hi(sat_hi), .sat_lo(sat_lo)
`endif
  );

  servo_pwm_gen #(
    .N(N), .FRAC(4), .PRESC(PRESC), .PERIOD(PERIOD),
    .OFFSET(OFFSET), .DUTY_MIN(DMIN), .DUTY_MAX(DMAX)
  ) dut4 (
    .clk(clk), .rst(rst), .en(en), .u(u4), .u_valid(u_valid4),
    .pwm(pwm4), .sample_tick(sample_tick4), .duty(duty4)
`ifdef SERVO_PWM_SAT_EN
    , .sat_hi(sat_hi4), .sat_lo(sat_lo4)
`endif
  );

  // Unclamped width: floor(u / 2^frac) + OFFSET.
  function automatic int ref_raw(input int uv, input int frac);
    int div;
    int q;
    div = 1 << frac;
    if (uv >= 0) q = uv / div;
    else         q = -((-uv + div - 1) / div);
    return q + OFFSET;
  endfunction

  function automatic int ref_duty(input int uv, input int frac);
    int w;
    w = ref_raw(uv, frac);
    if (w < DMIN) return DMIN;
    if (w > DMAX) return DMAX;
    return w;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Record a conversion of u (FRAC=0 instance) in the model's shadow.
  task automatic note_write(input int uv);
    shadow_m = ref_duty(uv, 0);
`ifdef SERVO_PWM_SAT_EN
    shi_m = (ref_raw(uv, 0) > DMAX);
    slo_m = (ref_raw(uv, 0) < DMIN);
`endif
  endtask

  task automatic wait_tick(output int clocks);
    clocks = 0;
    for (int i = 1; i <= 4 * CLKS; i++) begin
      step();
      if (sample_tick) begin
        clocks = i;
        return;
      end
    end
  endtask

  // Run one period from a tick sample to the next tick sample, counting high
  // pwm samples and injecting up to two u_valid strobes at sample indices ia/ib.
  task automatic measure(input int ia, input int ua, input int ib, input int ub,
                         output int len, output int hi);
    len = 0;
    hi  = 0;
    for (int i = 1; i <= 4 * CLKS; i++) begin
      step();
      u_valid4 = 1'b0;
      len = i;
      if (pwm) hi++;
      if (sample_tick) break;
      if (i == ia) begin
        u = N'(ua);
        u_valid = 1'b1;
      end else if (i == ib) begin
        u = N'(ub);
        u_valid = 1'b1;
      end else begin
        u_valid = 1'b0;
      end
    end
    u_valid = 1'b0;
  endtask

  // Check one full period against the model, then advance the model. A write
  // on sample index CLKS-1 lands on the wrap clock and misses this handover.
  task automatic run_period(input int ia, input int ua, input int ib, input int ub,
                            input string tag);
    int len, hi, nxt;
    check({tag, "_duty"}, duty, active_m);
    measure(ia, ua, ib, ub, len, hi);
    check({tag, "_len"}, len, CLKS);
    check({tag, "_high"}, hi, active_m * PRESC);
    nxt = shadow_m;
    if (ia >= 1 && ia <= CLKS - 2) nxt = ref_duty(ua, 0);
    if (ib >= 1 && ib <= CLKS - 2) nxt = ref_duty(ub, 0);
    if (ia >= 1 && ia <= CLKS - 1) note_write(ua);
    if (ib >= 1 && ib <= CLKS - 1) note_write(ub);
    active_m = nxt;
`ifdef SERVO_PWM_SAT_EN
    check({tag, "_sat_hi"}, sat_hi, shi_m);
    check({tag, "_sat_lo"}, sat_lo, slo_m);
`endif
  endtask

  initial begin
    int clocks, ia, ib, ua, ub, u4v, exp4;

    #2 rst = 1'b0;
    #10;
    check("rst_pwm", pwm, 0);
    check("rst_tick", sample_tick, 0);
    check("rst_duty", duty, 10);
    check("rst_pwm4", pwm4, 0);
`ifdef SERVO_PWM_SAT_EN
    check("rst_sat_hi", sat_hi, 0);
    check("rst_sat_lo", sat_lo, 0);
`endif
    rst = 1'b1;
    step();

    // FRAC=4 instance: -0x30 converts while still disabled.
    u4 = N'(-48);
    u_valid4 = 1'b1;
    step();
    u_valid4 = 1'b0;

    en = 1'b1;
    wait_tick(clocks);
    check("first_tick_clk", clocks, 1);
    check("frac4_duty", duty4, ref_duty(-48, 4));

    run_period(0, 0, 0, 0, "idle");
    run_period(10, 3, 0, 0, "u_p3_cur");
    run_period(5, 100, 0, 0, "u_p3_next");
    run_period(5, -100, 0, 0, "u_p100");
    run_period(CLKS - 1, 2, 0, 0, "u_m100");
    run_period(0, 0, 0, 0, "wrap_old");
    run_period(0, 0, 0, 0, "wrap_new");

    for (int k = 0; k < 10; k++) begin
      ia = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, CLKS - 1));
      ib = 0;
      if (ia != 0 && ia < CLKS - 1 && $urandom_range(0, 1) == 1)
        ib = int'($urandom_range(ia + 1, CLKS - 1));
      ua  = int'($urandom_range(0, 60)) - 30;
      ub  = int'($urandom_range(0, 60)) - 30;
      u4v = int'($urandom_range(0, 800)) - 400;
      exp4 = ref_duty(u4v, 4);
      u4 = N'(u4v);
      u_valid4 = 1'b1;
      run_period(ia, ua, ib, ub, "rand");
      check("rand_tick4", sample_tick4, 1);
      check("rand_duty4", duty4, exp4);
    end

    // Drop en mid-pulse, convert while disabled, then re-enable.
    repeat (4) step();
    check("endrop_pwm_hi", pwm, 1);
    en = 1'b0;
    step();
    check("endrop_pwm", pwm, 0);
    check("endrop_tick", sample_tick, 0);
    u = N'(-1);
    u_valid = 1'b1;
    step();
    u_valid = 1'b0;
    note_write(-1);
    repeat (3) step();
    check("dis_pwm", pwm, 0);
    en = 1'b1;
    step();
    check("reen_tick", sample_tick, 1);
    check("reen_pwm", pwm, 0);
    active_m = shadow_m;
    run_period(0, 0, 0, 0, "reen");

    // Asynchronous reset between clock edges while pwm is high.
    repeat (3) step();
    check("arst_pwm_hi", pwm, 1);
    #3 rst = 1'b0;
    #1;
    check("arst_pwm", pwm, 0);
    check("arst_duty", duty, 10);
    check("arst_tick", sample_tick, 0);
    shadow_m = 10;
    active_m = 10;
`ifdef SERVO_PWM_SAT_EN
    shi_m = 1'b0;
    slo_m = 1'b0;
`endif
    #2 rst = 1'b1;
    wait_tick(clocks);
    check("arst_restart_clk", clocks, 1);
    run_period(0, 0, 0, 0, "post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
